// File: rtl/alu32_pkg.sv
// rtl/alu32_pkg.sv - shared opcodes, widths and packed-entry flag layout for the ALU32 result stage
package alu32_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_LAST = 4'd6;

    // Flag positions above the result field: entry = {illegal, overflow, carry, negative, zero, result}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;
    localparam int FLAG_ILL   = 4;
    localparam int NUM_FLAGS  = 5;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu32_result_stage_if.sv
// rtl/alu32_result_stage_if.sv - upstream ALU unit bus and downstream result bus of the result stage
interface alu32_result_stage_if
    import alu32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] or_res;
    logic [WIDTH-1:0] xor_res;
    logic [WIDTH-1:0] sum_res;
    logic             sum_cout;
    logic [WIDTH-1:0] diff_res;
    logic             diff_cout;
    logic             a_sign;
    logic             b_sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             illegal;

    modport slave (
        input  in_valid, op, and_res, or_res, xor_res, sum_res, sum_cout,
               diff_res, diff_cout, a_sign, b_sign, out_ready,
        output in_ready, out_valid, result, zero, negative, carry, overflow, illegal
    );

    modport master (
        output in_valid, op, and_res, or_res, xor_res, sum_res, sum_cout,
               diff_res, diff_cout, a_sign, b_sign, out_ready,
        input  in_ready, out_valid, result, zero, negative, carry, overflow, illegal
    );
endinterface

// File: rtl/alu32_flag_buf.sv
// rtl/alu32_flag_buf.sv - two-entry FIFO of packed result+flag entries with registered-only handshake
module alu32_flag_buf
    import alu32_pkg::*;
#(
    parameter int EW    = WIDTH_DEF + NUM_FLAGS,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  logic [EW-1:0] push_data_i,
    output logic          pop_valid_o,
    input  logic          pop_ready_i,
    output logic [EW-1:0] pop_data_o
);
    buf_state_e    state_q, state_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic          push, pop;

    assign push_ready_o = (state_q != BUF_FULL);
    assign pop_valid_o  = (state_q != BUF_EMPTY);
    assign push         = push_valid_i & push_ready_o;
    assign pop          = pop_valid_o & pop_ready_i;
    assign pop_data_o   = pop_valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        case (state_q)
            BUF_EMPTY: if (push) state_d = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_d = BUF_FULL;
                else if (pop && !push) state_d = BUF_EMPTY;
            end
            BUF_FULL:  if (pop) state_d = BUF_ONE;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BUF_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entries are wiped on reset so nothing stale can resurface after a mid-run reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/alu32_result_stage.sv
// rtl/alu32_result_stage.sv - selects the ALU result, derives flags and buffers them for writeback
module alu32_result_stage
    import alu32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    alu32_result_stage_if.slave  bus
);
    localparam int EW = WIDTH + NUM_FLAGS;

    logic [WIDTH-1:0] sel;
    logic             ill, cy, ovf, ovf_add, ovf_sub;
    logic [EW-1:0]    push_entry;
    logic [EW-1:0]    head;

    assign ovf_add = (bus.a_sign == bus.b_sign) & (bus.sum_res[WIDTH-1]  != bus.a_sign);
    assign ovf_sub = (bus.a_sign != bus.b_sign) & (bus.diff_res[WIDTH-1] != bus.a_sign);

    always_comb begin
        sel = '0;
        ill = 1'b0;
        cy  = 1'b0;
        ovf = 1'b0;
        case (bus.op)
            OP_AND: sel = bus.and_res;
            OP_OR:  sel = bus.or_res;
            OP_XOR: sel = bus.xor_res;
            OP_NOR: sel = ~bus.or_res;
            OP_ADD: begin
                sel = bus.sum_res;
                cy  = bus.sum_cout;
                ovf = ovf_add;
            end
            OP_SUB: begin
                sel = bus.diff_res;
                cy  = bus.diff_cout;
                ovf = ovf_sub;
            end
            // Signed less-than: difference sign corrected by subtract overflow.
            OP_SLT: sel = {{(WIDTH-1){1'b0}}, bus.diff_res[WIDTH-1] ^ ovf_sub};
            default: ill = 1'b1;
        endcase
    end

    assign push_entry = {ill, ovf, cy, sel[WIDTH-1], (sel == '0), sel};

    alu32_flag_buf #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (bus.in_valid),
        .push_ready_o (bus.in_ready),
        .push_data_i  (push_entry),
        .pop_valid_o  (bus.out_valid),
        .pop_ready_i  (bus.out_ready),
        .pop_data_o   (head)
    );

    assign bus.result   = head[WIDTH-1:0];
    assign bus.zero     = head[WIDTH+FLAG_ZERO];
    assign bus.negative = head[WIDTH+FLAG_NEG];
    assign bus.carry    = head[WIDTH+FLAG_CARRY];
    assign bus.overflow = head[WIDTH+FLAG_OVF];
    assign bus.illegal  = head[WIDTH+FLAG_ILL];
endmodule

// File: tb/tb_alu32_result_stage.sv
// tb/tb_alu32_result_stage.sv - randomized scoreboard bench for alu32_result_stage
module tb_alu32_result_stage;
    import alu32_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu32_result_stage_if #(.WIDTH(W)) bus ();

    alu32_result_stage #(.WIDTH(W), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W+4:0] exp_q [$];
    logic [31:0]  cur_a = '0;
    logic [31:0]  cur_b = '0;

    // Reference: {illegal, overflow, carry, negative, zero, result} from the true operands.
    function automatic logic [W+4:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        il, ov, cy;
        longint      sa, sb, s, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        r = '0; il = 0; ov = 0; cy = 0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: begin
                r  = a + b;
                s  = sa + sb;
                cy = (ua + ub) > 64'sd4294967295;
                ov = (s > SMAX) || (s < SMIN);
            end
            4'd4: begin
                r  = a - b;
                s  = sa - sb;
                cy = (a >= b);
                ov = (s > SMAX) || (s < SMIN);
            end
            4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: r = ~(a | b);
            default: il = 1;
        endcase
        return {il, ov, cy, r[31], (r == 32'd0), r};
    endfunction

    task automatic chk(input string name, input logic [W+4:0] act, input logic [W+4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.op        = op;
        bus.and_res   = a & b;
        bus.or_res    = a | b;
        bus.xor_res   = a ^ b;
        {bus.sum_cout, bus.sum_res}   = {1'b0, a} + {1'b0, b};
        {bus.diff_cout, bus.diff_res} = {1'b0, a} + {1'b0, ~b} + 33'd1;
        bus.a_sign    = a[31];
        bus.b_sign    = b[31];
        bus.out_ready = ordy;
        cur_a = a;
        cur_b = b;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            drive(0, OP_AND, 0, 0, 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0 entries left", exp_q.size());
        end
    endtask

    // Monitor: head/handshake checked against the queue, then pop and push as the model dictates.
    always @(negedge clk) begin
        if (!rst) begin
            int sz;
            sz = exp_q.size();
            chk("in_ready", {{(W+4){1'b0}}, bus.in_ready}, {{(W+4){1'b0}}, (sz != 2)});
            chk("out_valid", {{(W+4){1'b0}}, bus.out_valid}, {{(W+4){1'b0}}, (sz != 0)});
            if (bus.out_valid && sz != 0)
                chk("head", {bus.illegal, bus.overflow, bus.carry, bus.negative, bus.zero, bus.result}, exp_q[0]);
            if (bus.out_valid && bus.out_ready && sz != 0)
                void'(exp_q.pop_front());
            if (bus.in_valid && sz < 2)
                exp_q.push_back(model(bus.op, cur_a, cur_b));
        end
    end

    initial begin
        bus.in_valid = 0; bus.op = 0; bus.and_res = 0; bus.or_res = 0; bus.xor_res = 0;
        bus.sum_res = 0; bus.sum_cout = 0; bus.diff_res = 0; bus.diff_cout = 0;
        bus.a_sign = 0; bus.b_sign = 0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #3 rst = 0;
        @(negedge clk);
        #1;
        chk("reset_state", {bus.illegal, bus.overflow, bus.carry, bus.negative, bus.zero, bus.result}, '0);

        drive(1, OP_XOR, 32'hA5A5_5A5A, 32'h0, 1);
        drive(1, OP_ADD, 32'h4000_0000, 32'h4000_0000, 1);
        drive(1, OP_SUB, 32'h1234_5678, 32'h1234_5678, 1);
        drive(1, OP_SLT, 32'h8000_0000, 32'h0000_0001, 1);
        drain();

        // Back-pressure: AND then OR fill the buffer, the third offer must be ignored.
        drive(1, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        drive(1, OP_OR,  32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        drive(1, OP_XOR, 32'h1111_1111, 32'h2222_2222, 0);
        drive(0, OP_AND, 0, 0, 0);
        drain();

        for (int i = 0; i < 8; i++)
            drive(1, 4'($urandom_range(0, 6)), rnd32(), rnd32(), 1);
        drive(1, 4'd9, rnd32(), rnd32(), 1);
        drain();

        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6)),
                  rnd32(), rnd32(), $urandom_range(0, 3) != 0);
        drain();

        // Reset while FULL: outputs must clear before any clock edge.
        drive(1, OP_ADD, 32'h7FFF_FFFF, 32'h1, 0);
        drive(1, OP_NOR, 32'h1234_0000, 32'h0, 0);
        @(posedge clk);
        #2;
        bus.in_valid = 0;
        rst = 1;
        #1;
        chk("rst_out_valid", {{(W+4){1'b0}}, bus.out_valid}, '0);
        chk("rst_in_ready", {{(W+4){1'b0}}, bus.in_ready}, {{(W+4){1'b0}}, 1'b1});
        chk("rst_head", {bus.illegal, bus.overflow, bus.carry, bus.negative, bus.zero, bus.result}, '0);
        exp_q.delete();
        @(posedge clk);
        #3 rst = 0;
        repeat (3) drive(0, OP_AND, 0, 0, 1);
        drive(1, OP_SUB, 32'h0000_0001, 32'h0000_0002, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
